codec_serdes: RTL and testbench

//  Single-clock serial interface to the audio codec: generates BCLK/LRCK, shifts
//  the filtered sample out on DACDAT and deserialises ADCDAT into 16-bit samples.

---
 rtl/codec_serdes.sv | 102 ++++++++++
 tb/tb_codec_serdes.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/codec_serdes.sv
// Serial audio codec interface: generates BCLK/LRCK, serialises the playback
// sample onto DACDAT and deserialises the left-channel ADCDAT word.
module codec_serdes #(
    parameter int BCLK_DIV = 8
) (
    input  logic        main_clk,
    input  logic        reset_n,
    output logic        aud_bclk,
    output logic        aud_lrck,
    output logic        aud_dacdat,
    input  logic        aud_adcdat,
    input  logic [15:0] audio_output,
    output logic        sample_req,
    output logic [15:0] audio_input,
    output logic        sample_end
);

    localparam int                DIV_W    = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(BCLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic [5:0]       bit_cnt;
    logic [5:0]       bit_cnt_nxt;
    logic [15:0]      tx_hold;
    logic [31:0]      tx_shift;
    logic [15:0]      rx_shift;
    logic             rx_done;
    logic             div_wrap;
    logic             rise_evt;
    logic             fall_evt;

    // Bit-clock edges are decided one cycle ahead so every consumer sees the
    // event in the same cycle the bit clock actually toggles.
    always_comb begin
        div_wrap    = (div_cnt == DIV_LAST);
        rise_evt    = div_wrap && !aud_bclk;
        fall_evt    = div_wrap && aud_bclk;
        bit_cnt_nxt = bit_cnt + 6'd1;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge main_clk) begin
        if (!reset_n) begin
            div_cnt  <= '0;
            aud_bclk <= 1'b0;
        end else begin
            div_cnt <= div_wrap ? '0 : div_cnt + 1'b1;
            if (div_wrap) begin
                aud_bclk <= ~aud_bclk;
            end
        end
    end

    // Frame sequencing and DAC shifter: everything moves on the falling BCLK.
    always_ff @(posedge main_clk) begin
        if (!reset_n) begin
            bit_cnt    <= '0;
            aud_lrck   <= 1'b0;
            sample_req <= 1'b0;
            tx_hold    <= '0;
            tx_shift   <= '0;
        end else begin
            sample_req <= fall_evt && (bit_cnt_nxt == 6'd63);
            if (fall_evt) begin
                bit_cnt  <= bit_cnt_nxt;
                aud_lrck <= bit_cnt_nxt[5];
                if (bit_cnt_nxt == 6'd0) begin
                    tx_hold  <= audio_output;
                    tx_shift <= {audio_output, 16'h0000};
                end else if (bit_cnt_nxt == 6'd32) begin
                    // Right slot repeats the sample held at frame start.
                    tx_shift <= {tx_hold, 16'h0000};
                end else begin
                    tx_shift <= {tx_shift[30:0], 1'b0};
                end
            end
        end
    end

    assign aud_dacdat = tx_shift[31];

    // ADC capture on rising BCLK, first 16 bits of the left slot only.
    always_ff @(posedge main_clk) begin
        if (!reset_n) begin
            rx_shift    <= '0;
            rx_done     <= 1'b0;
            audio_input <= '0;
            sample_end  <= 1'b0;
        end else begin
            rx_done    <= rise_evt && (bit_cnt == 6'd15);
            sample_end <= rx_done;
            if (rise_evt && (bit_cnt[5:4] == 2'b00)) begin
                rx_shift <= {rx_shift[14:0], aud_adcdat};
            end
            if (rx_done) begin
                audio_input <= rx_shift;
            end
        end
    end

endmodule

// File: tb/tb_codec_serdes.sv
// Directed bench for codec_serdes at BCLK_DIV=2: frame timing table plus
// hand-written sequences for DAC framing, loopback, ADC slot gating and reset.
module tb_codec_serdes;

    localparam int BCLK_DIV = 2;

    logic        main_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        aud_adcdat = 1'b0;
    logic [15:0] audio_output = '0;
    logic        aud_bclk;
    logic        aud_lrck;
    logic        aud_dacdat;
    logic        sample_req;
    logic [15:0] audio_input;
    logic        sample_end;

    codec_serdes #(.BCLK_DIV(BCLK_DIV)) dut (
        .main_clk    (main_clk),
        .reset_n     (reset_n),
        .aud_bclk    (aud_bclk),
        .aud_lrck    (aud_lrck),
        .aud_dacdat  (aud_dacdat),
        .aud_adcdat  (aud_adcdat),
        .audio_output(audio_output),
        .sample_req  (sample_req),
        .audio_input (audio_input),
        .sample_end  (sample_end)
    );

    always #5 main_clk = ~main_clk;

    typedef struct {
        int          cyc;
        logic [15:0] aout;
        logic        bclk;
        logic        lrck;
        logic        dac;
        logic        req;
        logic        send;
    } vec_t;

    vec_t tv[$];

    int cyc;
    int n_vec;
    int n_err;
    int n_req;
    int n_end;
    int n_both;
    int end_last;
    int end_prev;
    int adc_mode;   // 0: zero, 1: loopback, 2: right slot ones, 3: left bits 0..15 ones

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic drive_adc();
        case (adc_mode)
            1:       aud_adcdat = aud_dacdat;
            2:       aud_adcdat = ((cyc % 256) >= 128);
            3:       aud_adcdat = ((cyc % 256) < 64);
            default: aud_adcdat = 1'b0;
        endcase
    endtask

    // cyc counts edges since reset release; outputs are sampled 1 ns after each edge.
    task automatic step();
        @(posedge main_clk);
        #1;
        cyc++;
        if (sample_req) n_req++;
        if (sample_end) begin
            n_end++;
            end_prev = end_last;
            end_last = cyc;
        end
        if (sample_req && sample_end) n_both++;
        drive_adc();
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) step();
    endtask

    task automatic do_reset(input int cycles);
        reset_n = 1'b0;
        repeat (cycles) step();
        reset_n  = 1'b1;
        cyc      = 0;
        n_req    = 0;
        n_end    = 0;
        n_both   = 0;
        end_last = 0;
        end_prev = 0;
        drive_adc();
    endtask

    task automatic check_zero(input string name);
        check(name, {aud_bclk, aud_lrck, aud_dacdat, sample_req, sample_end, audio_input},
              64'h0);
    endtask

    task automatic capture_frame(input int base, output logic [63:0] dac_bits,
                                 output logic [63:0] lr_bits);
        for (int k = 0; k < 64; k++) begin
            wait_until(base + 4 * k + 3);
            dac_bits[63-k] = aud_dacdat;
            lr_bits[63-k]  = aud_lrck;
        end
    endtask

    task automatic run_timing_table(input string tag);
        for (int i = 0; i < tv.size(); i++) begin
            audio_output = tv[i].aout;
            wait_until(tv[i].cyc);
            check($sformatf("%s_v%0d", tag, i),
                  {aud_bclk, aud_lrck, aud_dacdat, sample_req, sample_end},
                  {tv[i].bclk, tv[i].lrck, tv[i].dac, tv[i].req, tv[i].send});
        end
        check({tag, "_req_cnt"}, n_req, 1);
        check({tag, "_end_cnt"}, n_end, 1);
        check({tag, "_both"}, n_both, 0);
    endtask

    logic [63:0] dac_bits;
    logic [63:0] lr_bits;

    initial begin
        // cyc, aout, bclk, lrck, dac, req, sample_end
        tv.push_back('{1,   16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        tv.push_back('{2,   16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        tv.push_back('{3,   16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        tv.push_back('{4,   16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        tv.push_back('{5,   16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        tv.push_back('{6,   16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        tv.push_back('{8,   16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        tv.push_back('{62,  16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        tv.push_back('{63,  16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1});
        tv.push_back('{64,  16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        tv.push_back('{127, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        tv.push_back('{128, 16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
        tv.push_back('{251, 16'hFFFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
        tv.push_back('{252, 16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0});
        tv.push_back('{253, 16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
        tv.push_back('{255, 16'hFFFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
        tv.push_back('{256, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
        tv.push_back('{258, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});

        n_vec    = 0;
        n_err    = 0;
        cyc      = 0;
        adc_mode = 0;

        // Reset state and frame timing from release.
        audio_output = 16'hFFFF;
        do_reset(5);
        check_zero("reset_outputs");
        run_timing_table("timing");

        // Frame 0 silent, frame 1 carries 0x8001 in both slots.
        audio_output = 16'h8001;
        do_reset(5);
        capture_frame(0, dac_bits, lr_bits);
        check("frame0_dac", dac_bits, 64'h0);
        capture_frame(256, dac_bits, lr_bits);
        check("frame1_dac", dac_bits, {16'h8001, 16'h0000, 16'h8001, 16'h0000});
        check("frame1_lrck", lr_bits, 64'h0000_0000_FFFF_FFFF);

        // Loopback DACDAT -> ADCDAT.
        audio_output = 16'hA5C3;
        adc_mode     = 1;
        do_reset(5);
        wait_until(320);
        check("loop_first", audio_input, 16'hA5C3);
        n_req  = 0;
        n_end  = 0;
        n_both = 0;
        wait_until(832);
        check("loop_end_cnt", n_end, 2);
        check("loop_req_cnt", n_req, 2);
        check("loop_both", n_both, 0);
        check("loop_end_last", end_last, 831);
        check("loop_end_period", end_last - end_prev, 256);
        check("loop_hold", audio_input, 16'hA5C3);

        // Sample is frozen at frame start.
        adc_mode     = 0;
        audio_output = 16'h1234;
        do_reset(5);
        while (!sample_req && cyc < 300) step();
        check("req_cycle", cyc, 252);
        wait_until(259);
        audio_output = 16'h0F0F;
        capture_frame(256, dac_bits, lr_bits);
        check("late_change_cur", dac_bits, {16'h1234, 16'h0000, 16'h1234, 16'h0000});
        capture_frame(512, dac_bits, lr_bits);
        check("late_change_next", dac_bits, {16'h0F0F, 16'h0000, 16'h0F0F, 16'h0000});

        // ADC slot gating.
        audio_output = 16'h0000;
        adc_mode     = 2;
        do_reset(5);
        wait_until(320);
        check("adc_right_only", audio_input, 16'h0000);
        check("adc_right_ends", n_end, 2);
        adc_mode = 3;
        wait_until(576);
        check("adc_left16", audio_input, 16'hFFFF);

        // Mid-frame reset at bit 20 of frame 1.
        audio_output = 16'hFFFF;
        adc_mode     = 3;
        do_reset(5);
        wait_until(338);
        check("pre_reset_input", audio_input, 16'hFFFF);
        adc_mode = 0;
        do_reset(1);
        check_zero("midframe_reset");
        run_timing_table("restart");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
